keystream_gen: RTL and testbench

- Upstream stage of the 8-bit cipher datapath. Generates the 8-bit keystream byte that feeds the b operand of the byte-wide XOR stage (the a operand is plaintext or ciphertext).
- Uses a 16-bit Galois LFSR seeded from a 16-bit key and steps it once per cycle. Eight steps produce one keystream byte.
- Each byte is offered on a valid/ready handshake, so the XOR stage and the UART framing can stall it.

---
 rtl/crypto_pkg.sv | 20 ++
 rtl/keystream_gen_lfsr_step.sv | 14 +
 rtl/keystream_gen.sv | 79 +++++++
 tb/tb_keystream_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// Shared constants and types for the 8-bit cipher datapath.
package crypto_pkg;

    localparam int          LFSR_W    = 16;
    localparam int          BYTE_W    = 8;
    localparam logic [15:0] TAP_MASK  = 16'hB400;  // x^16+x^14+x^13+x^11+1
    localparam logic [15:0] ZERO_SEED = 16'hACE1;  // replaces an all-zero key

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } ks_state_t;

    // Seed actually loaded for a given key; an all-zero state would lock up the LFSR.
    function automatic logic [LFSR_W-1:0] seed_of(input logic [LFSR_W-1:0] key);
        return (key == '0) ? ZERO_SEED : key;
    endfunction

endpackage

// File: rtl/keystream_gen_lfsr_step.sv
// One step of a right-shifting Galois LFSR; purely combinational.
module lfsr_step
    import crypto_pkg::*;
(
    input  logic [LFSR_W-1:0] s,
    input  logic [LFSR_W-1:0] mask,
    output logic [LFSR_W-1:0] s_next,
    output logic              out_bit
);

    assign out_bit = s[0];
    assign s_next  = (s >> 1) ^ (s[0] ? mask : '0);

endmodule

// File: rtl/keystream_gen.sv
// Keystream byte generator: 16-bit Galois LFSR, eight steps per byte,
// byte offered on a valid/ready handshake.
module keystream_gen
    import crypto_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic [LFSR_W-1:0] key,
    input  logic              ks_ready,
    output logic              ks_valid,
    output logic [BYTE_W-1:0] ks_byte,
    output logic              busy
);

    ks_state_t         state, state_nxt;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic              out_bit;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-2:0] partial;   // bits 0..6 of the byte being assembled

    lfsr_step u_step (
        .s       (lfsr),
        .mask    (TAP_MASK),
        .s_next  (lfsr_nxt),
        .out_bit (out_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status outputs; key_load overrides every other transition.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_nxt = state;
        ks_valid  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:  state_nxt = IDLE;
            SHIFT: begin
                busy = 1'b1;
                if (bit_cnt == 3'd7) state_nxt = HOLD;
            end
            HOLD: begin
                ks_valid = 1'b1;
                if (ks_ready) state_nxt = SHIFT;
            end
            default: state_nxt = IDLE;
        endcase
        if (key_load) state_nxt = SHIFT;
    end

    // LFSR, bit counter and LSB-first byte assembly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr    <= '0;
            bit_cnt <= '0;
            partial <= '0;
            ks_byte <= '0;
        end else if (key_load) begin
            lfsr    <= seed_of(key);
            bit_cnt <= '0;
        end else if (state == SHIFT) begin
            lfsr    <= lfsr_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            partial <= {out_bit, partial[BYTE_W-2:1]};
            if (bit_cnt == 3'd7) ks_byte <= {out_bit, partial};
        end else if (state == HOLD && ks_ready) begin
            bit_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_keystream_gen.sv
// Scoreboard bench for keystream_gen: stimulus pushes expected bytes and the
// cycle at which ks_valid should rise; a negedge monitor pops and compares.
module tb_keystream_gen;

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_load;
    logic [15:0] key;
    logic        ks_ready;
    logic        ks_valid;
    logic [7:0]  ks_byte;
    logic        busy;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    keystream_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_load (key_load),
        .key      (key),
        .ks_ready (ks_ready),
        .ks_valid (ks_valid),
        .ks_byte  (ks_byte),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Rising-edge counter used for latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] k, output int edge_cyc);
        key      = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        edge_cyc = cyc;
        check("busy_after_load", busy, 1);
        check("valid_after_load", ks_valid, 0);
    endtask

    task automatic wait_valid(input int max_cycles);
        int n = 0;
        while (!ks_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check("valid_timeout", ks_valid, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid"}, ks_valid, 0);
        check({name, "_byte"},  ks_byte,  8'h00);
        check({name, "_busy"},  busy,     0);
    endtask

    // Monitor: on each rising ks_valid, pop one expectation and compare byte
    // and arrival cycle; while valid stays high, the byte must not move.
    logic       prev_valid = 1'b0;
    logic [7:0] held_byte  = 8'h00;
    always @(negedge clk) begin
        exp_t e;
        if (ks_valid && !prev_valid) begin
            check("expectation_pending", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ks_byte", ks_byte, e.b);
                check("valid_latency", cyc, e.cyc);
            end
            held_byte <= ks_byte;
        end else if (ks_valid && prev_valid) begin
            check("hold_stable", ks_byte, held_byte);
        end
        prev_valid <= ks_valid;
    end

    initial begin
        int l;
        rst_n    = 1'b0;
        key_load = 1'b0;
        key      = 16'h0000;
        ks_ready = 1'b0;

        // Reset, then idle with no key_load.
        repeat (2) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (20) begin
            tick();
            check_reset_outputs("idle");
        end

        // Seed ACE1 with ks_ready high: E1 then C4.
        ks_ready = 1'b1;
        load(16'hACE1, l);
        exp_q.push_back('{b: 8'hE1, cyc: l + 8});
        wait_valid(12);
        tick();
        exp_q.push_back('{b: 8'hC4, cyc: cyc + 8});
        wait_valid(12);
        ks_ready = 1'b0;

        // Zero key falls back to ACE1 and yields the same stream.
        load(16'h0000, l);
        exp_q.push_back('{b: 8'hE1, cyc: l + 8});
        ks_ready = 1'b1;
        wait_valid(12);
        tick();
        exp_q.push_back('{b: 8'hC4, cyc: cyc + 8});
        wait_valid(12);
        ks_ready = 1'b0;

        // Backpressure: byte and status frozen for 30 cycles.
        load(16'hACE1, l);
        exp_q.push_back('{b: 8'hE1, cyc: l + 8});
        wait_valid(12);
        repeat (30) begin
            tick();
            check("bp_byte",  ks_byte,  8'hE1);
            check("bp_valid", ks_valid, 1);
            check("bp_busy",  busy,     0);
        end
        ks_ready = 1'b1;
        tick();
        exp_q.push_back('{b: 8'hC4, cyc: cyc + 8});
        wait_valid(12);
        ks_ready = 1'b0;

        // Reseed at SHIFT cycle 4: partial byte discarded.
        load(16'hACE1, l);
        repeat (4) tick();
        load(16'h1234, l);
        exp_q.push_back('{b: 8'h34, cyc: l + 8});
        wait_valid(12);

        // key_load coincident with a handshake: one transfer, then fresh byte.
        ks_ready = 1'b1;
        load(16'h1234, l);
        ks_ready = 1'b0;
        exp_q.push_back('{b: 8'h34, cyc: l + 8});
        wait_valid(12);

        // Reset mid-HOLD.
        rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        ks_ready = 1'b1;
        repeat (5) begin
            tick();
            check_reset_outputs("post_rst_idle");
        end
        ks_ready = 1'b0;

        // Reset mid-SHIFT.
        load(16'hACE1, l);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_shift");
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            check_reset_outputs("post_rst_shift");
        end

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
